// File: rtl/data_mem_bank.sv
// Word-addressed data RAM with per-lane write mask, registered read port and a zeroing clear sweep.
// Optional per-lane even parity is enabled by defining DATA_MEM_BANK_PARITY_EN.
module data_mem_bank #(
    parameter int LEN_ADDR  = 11,
    parameter int LEN_DATA  = 16,
    parameter int LEN_LANE  = 8,
    parameter int RAM_DEPTH = 2048
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_rd,
    input  logic                           i_wr,
    input  logic [LEN_ADDR-1:0]            i_addr,
    input  logic [LEN_DATA-1:0]            i_data,
    input  logic [LEN_DATA/LEN_LANE-1:0]   i_wr_mask,
    input  logic                           i_clear,
    output logic [LEN_DATA-1:0]            o_data,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic                           o_par_err
);
    localparam int LANES = LEN_DATA / LEN_LANE;
    localparam logic [LEN_ADDR:0]   DEPTH_W   = (LEN_ADDR+1)'(RAM_DEPTH);
    localparam logic [LEN_ADDR-1:0] LAST_ADDR = LEN_ADDR'(RAM_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic logic [LANES-1:0] lane_parity(input logic [LEN_DATA-1:0] w);
        logic [LANES-1:0] p;
        for (int k = 0; k < LANES; k++) begin
            p[k] = ^w[k*LEN_LANE +: LEN_LANE];
        end
        return p;
    endfunction

    state_t                state_q, state_d;
    logic [LEN_ADDR-1:0]   cnt_q, cnt_d;
    logic [LEN_DATA-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  par_err_q, par_err_d;

    logic [LEN_DATA-1:0]   mem_q [RAM_DEPTH];
`ifdef DATA_MEM_BANK_PARITY_EN
    logic [LANES-1:0]      par_q [RAM_DEPTH];
`endif

    logic                  addr_ok_s;
    logic [LEN_DATA-1:0]   rd_word_s;
    logic                  rd_par_err_s;
    logic                  mem_we_s;
    logic [LEN_ADDR-1:0]   mem_waddr_s;
    logic [LEN_DATA-1:0]   mem_wdata_s;
    logic [LANES-1:0]      mem_wmask_s;

    assign addr_ok_s = ({1'b0, i_addr} < DEPTH_W);
    assign rd_word_s = mem_q[i_addr];
`ifdef DATA_MEM_BANK_PARITY_EN
    assign rd_par_err_s = |(lane_parity(rd_word_s) ^ par_q[i_addr]);
`else
    assign rd_par_err_s = 1'b0;
`endif

    // Next-state, sweep counter, read result and memory write-port control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        par_err_d   = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = i_addr;
        mem_wdata_s = i_data;
        mem_wmask_s = i_wr_mask;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q;
                mem_wdata_s = {LEN_DATA{1'b0}};
                mem_wmask_s = {LANES{1'b1}};
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = {LEN_ADDR{1'b0}};
                end else begin
                    cnt_d = cnt_q + LEN_ADDR'(1);
                end
            end
            ST_IDLE: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {LEN_ADDR{1'b0}};
                end else if (i_wr && !i_rd) begin
                    mem_we_s = addr_ok_s;
                end else if (i_rd && !i_wr) begin
                    valid_d = 1'b1;
                    if (addr_ok_s) begin
                        data_d    = rd_word_s;
                        par_err_d = rd_par_err_s;
                    end else begin
                        data_d = {LEN_DATA{1'b0}};
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {LEN_ADDR{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= {LEN_ADDR{1'b0}};
            data_q    <= {LEN_DATA{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            par_err_q <= par_err_d;
        end
    end

    // Storage array: lane-masked write, no reset (the sweep zeroes it)
    always_ff @(posedge clk) begin
        if (mem_we_s && !reset) begin
            for (int k = 0; k < LANES; k++) begin
                if (mem_wmask_s[k]) begin
                    mem_q[mem_waddr_s][k*LEN_LANE +: LEN_LANE] <= mem_wdata_s[k*LEN_LANE +: LEN_LANE];
`ifdef DATA_MEM_BANK_PARITY_EN
                    par_q[mem_waddr_s][k] <= lane_parity(mem_wdata_s)[k];
`endif
                end
            end
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;
    assign o_par_err = par_err_q;
endmodule

// File: doc/data_mem_bank.md
# data_mem_bank

Parametrised data memory for the BIP datapath and the next generation of the single-port data RAM. It provides per-lane write masking, a registered read output with a one-cycle valid strobe, and a hardware clear sweep that zeroes the whole array after reset or on request. It sits between the execution stage and the data address bus. Optional per-lane parity detects storage corruption.

## Interface
Parameters:
- `LEN_ADDR`, 11, address width.
- `LEN_DATA`, 16, word width; must be a multiple of `LEN_LANE`.
- `LEN_LANE`, 8, write-mask lane width. `LANES = LEN_DATA/LEN_LANE`.
- `RAM_DEPTH`, 2048, number of words; must be ≤ 2^`LEN_ADDR`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `i_rd`  in  1  read request.
- `i_wr`  in  1  write request.
- `i_addr`  in  `LEN_ADDR`  word address.
- `i_data`  in  `LEN_DATA`  write data.
- `i_wr_mask`  in  `LANES`  lane enable; bit k covers `i_data[k*LEN_LANE +: LEN_LANE]`.
- `i_clear`  in  1  start a clear sweep (pulse).
- `o_data`  out  `LEN_DATA`  registered read data.
- `o_valid`  out  1  one-cycle strobe: `o_data` updated this cycle.
- `o_busy`  out  1  clear sweep in progress; requests ignored.
- `o_par_err`  out  1  parity mismatch on the current read; qualified by `o_valid`.

## Operation
- FSM states: CLEAR and IDLE.
- Reset enters CLEAR with the sweep counter at 0.
- CLEAR:
  - Writes all-zero data (and zero parity) to address `cnt` each cycle, then increments `cnt`.
  - After writing `RAM_DEPTH-1`, moves to IDLE.
  - `i_rd`, `i_wr` and `i_clear` are ignored.
  - `o_valid` stays 0 and `o_data` holds its value.
- IDLE:
  - `i_clear` = 1: enter CLEAR with `cnt` = 0. This takes priority over `i_rd`/`i_wr` in the same cycle; no access is performed.
  - `i_wr` = 1 and `i_rd` = 0: write the lanes whose mask bit is set; unmasked lanes keep their contents. A mask of all zeros is a no-op.
  - `i_rd` = 1 and `i_wr` = 0: on the next edge, `o_data` = mem[`i_addr`] and `o_valid` = 1 for exactly one cycle.
  - `i_rd` = `i_wr` = 1: no operation; memory unchanged and `o_valid` = 0.
  - `o_data` holds the last read value until the next read completes.
- Out-of-range address (`i_addr` ≥ `RAM_DEPTH`): writes are dropped; reads return all zeros with `o_valid` = 1 and `o_par_err` = 0.
- Reset in the middle of a sweep restarts the sweep at address 0. Reset in IDLE discards any in-flight read: `o_valid` = 0 on the following cycle.

## Timing
- Reset values: `o_data` = 0, `o_valid` = 0, `o_busy` = 1, `o_par_err` = 0.
- `o_busy` is a registered output and is 1 in every cycle the FSM is in CLEAR.
- Clear sweep after reset deassertion:
  - First edge with `reset` = 0 writes address 0.
  - Edge N writes address N-1.
  - `o_busy` falls after the edge that writes `RAM_DEPTH-1`; total busy time after reset deassertion is `RAM_DEPTH` cycles.
- `i_clear` sampled at edge T: `o_busy` = 1 from T to T+`RAM_DEPTH`.
- Read latency is 1 cycle. A request sampled at edge T produces `o_data`/`o_valid` after T.
- Back-to-back reads sustain one per cycle; `o_valid` stays high throughout.
- Write at edge T followed by a read of the same address at T+1 returns the new data (no forwarding needed).

## Configuration
- Macro `DATA_MEM_BANK_PARITY_EN`.
- Defined:
  - Each lane stores one extra even-parity bit, computed from `i_data` on write; the clear sweep writes parity 0.
  - On read, `o_par_err` = 1 in the `o_valid` cycle if any lane's stored parity mismatches its stored data; otherwise 0.
  - `o_par_err` is 0 whenever `o_valid` = 0.
- Undefined: no parity storage; `o_par_err` is tied to 0. The port list is identical in both builds.

## Test plan
- Reset sweep: hold `reset` for 3 cycles, release → `o_busy` = 1 for exactly 2048 cycles; afterwards reading addresses 0, 1000 and 2047 returns 0x0000.
- Masked write: write 0xABCD to address 5 with mask 2'b11, then 0x1234 with mask 2'b01, then read 5 → `o_data` = 0xAB34 and `o_valid` high for one cycle.
- Conflicts: `i_rd` = `i_wr` = 1 at address 7 with data 0xFFFF → `o_valid` = 0 and address 7 still reads 0x0000. Requests issued while `o_busy` = 1 have no effect.
- Mid-sweep events:
  - Pulse `i_clear` after filling addresses 0–9 → all read 0 after `RAM_DEPTH` cycles.
  - Assert `reset` at sweep count 500 → the sweep restarts, and `o_busy` stays high for a further 2048 cycles after release.
- Pipelined reads: consecutive reads of addresses 1, 2, 3 (holding 0x11, 0x22, 0x33) → `o_data` sequence 0x11, 0x22, 0x33 on consecutive cycles with `o_valid` continuously 1. With `RAM_DEPTH` = 1000 and `i_addr` = 1500, a write is dropped and a read returns 0.
- Parity (`DATA_MEM_BANK_PARITY_EN` defined): write 0x00FF, then force-flip bit 0 of the stored word and read → `o_par_err` = 1 together with `o_valid`. Without the macro → `o_par_err` = 0.
